// File: rtl/skin_pkg.sv
// Shared types and defaults for the skin-tone bounding-box detector.
// bbox_t serves both as the running accumulator and the per-frame latched copy.
package skin_pkg;

    localparam int CW_DEF = 12;
    localparam int NW_DEF = 22;

    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;

    localparam logic [NW_DEF-1:0] MIN_PIX_DEF = 22'd64;

    localparam logic [23:0] BOX_COLOR_DEF = 24'hFF0000;
    localparam logic [23:0] MASK_ON       = 24'hFFFFFF;
    localparam logic [23:0] MASK_OFF      = 24'h000000;

    typedef struct packed {
        logic [CW_DEF-1:0] x_min;
        logic [CW_DEF-1:0] x_max;
        logic [CW_DEF-1:0] y_min;
        logic [CW_DEF-1:0] y_max;
        logic [NW_DEF-1:0] cnt;
    } bbox_t;

    // Empty box: min at all-ones and max at zero so the first hit wins both.
    function automatic bbox_t bbox_init();
        bbox_t b;
        b.x_min = '1;
        b.x_max = '0;
        b.y_min = '1;
        b.y_max = '0;
        b.cnt   = '0;
        return b;
    endfunction

endpackage

// File: rtl/skin_bbox_detect_if.sv
// Video stream bundle into and out of the skin detector.
// master drives the i_ side (source), slave is the detector.
interface skin_bbox_detect_if;

    logic [23:0] i_ycbcr;
    logic [23:0] i_rgb;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;
    logic        i_mode;

    logic [23:0] o_rgb;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic        o_mask;

    modport master (
        output i_ycbcr, i_rgb, i_hsync, i_vsync, i_de, i_mode,
        input  o_rgb, o_hsync, o_vsync, o_de, o_mask
    );

    modport slave (
        input  i_ycbcr, i_rgb, i_hsync, i_vsync, i_de, i_mode,
        output o_rgb, o_hsync, o_vsync, o_de, o_mask
    );

endinterface

// File: rtl/video_pos_counter.sv
// Pixel x/y position tracking and frame-start pulse detection.
// Outputs are registered so they line up with the detector's first stage.
module video_pos_counter #(
    parameter int   CW     = 12,
    parameter logic VS_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_frame_start
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [CW-1:0] xs_q, xs_d;
    logic [CW-1:0] ys_q, ys_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic          fs;
    logic          de_fall;

    always_comb begin
        fs      = (i_vsync == VS_POL) && (vs_q != VS_POL);
        de_fall = de_q && !i_de;
        vs_d    = i_vsync;
        de_d    = i_de;
        x_d     = '0;
        if (i_de) begin
            x_d = (&x_q) ? x_q : x_q + ONE;
        end
        y_d = y_q;
        if (fs) begin
            y_d = '0;
        end else if (de_fall && !(&y_q)) begin
            y_d = y_q + ONE;
        end
        xs_d = x_q;
        ys_d = y_q;
        fs_d = fs;
    end

    // vs_q starts at the active level so a vsync already high at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            xs_q <= '0;
            ys_q <= '0;
            vs_q <= VS_POL;
            de_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            xs_q <= xs_d;
            ys_q <= ys_d;
            vs_q <= vs_d;
            de_q <= de_d;
            fs_q <= fs_d;
        end
    end

    assign o_x           = xs_q;
    assign o_y           = ys_q;
    assign o_frame_start = fs_q;

endmodule

// File: rtl/skin_bbox_detect.sv
// Cb/Cr skin classifier with per-frame bounding box and overlay/mask output.
// Two-stage pipeline: classify + position, then accumulate + pixel select.
module skin_bbox_detect
    import skin_pkg::*;
#(
    parameter int              CW        = CW_DEF,
    parameter int              NW        = NW_DEF,
    parameter logic [7:0]      CB_MIN    = CB_MIN_DEF,
    parameter logic [7:0]      CB_MAX    = CB_MAX_DEF,
    parameter logic [7:0]      CR_MIN    = CR_MIN_DEF,
    parameter logic [7:0]      CR_MAX    = CR_MAX_DEF,
    parameter logic [NW-1:0]   MIN_PIX   = MIN_PIX_DEF,
    parameter logic [23:0]     BOX_COLOR = BOX_COLOR_DEF,
    parameter logic            VS_POL    = 1'b1
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    skin_bbox_detect_if.slave vid,
    output logic              o_box_valid,
    output logic [CW-1:0]     o_x_min,
    output logic [CW-1:0]     o_x_max,
    output logic [CW-1:0]     o_y_min,
    output logic [CW-1:0]     o_y_max,
    output logic [NW-1:0]     o_pix_cnt
);

    localparam logic [NW-1:0] CNT_ONE = NW'(1);

    logic [7:0]    cb, cr;
    logic [CW-1:0] x_s1, y_s1;
    logic          fs_s1;

    logic [23:0] rgb_s1_q, rgb_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic        de_s1_q, de_s1_d;
    logic        mode_s1_q, mode_s1_d;
    logic        skin_s1_q, skin_s1_d;

    bbox_t       acc_q, acc_d;
    bbox_t       box_q, box_d;
    logic        valid_q, valid_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, de_q, mask_q;

    logic on_x, on_y, in_x, in_y, border;

    video_pos_counter #(
        .CW     (CW),
        .VS_POL (VS_POL)
    ) u_pos (
        .clk           (pixelclk),
        .rst_n         (reset_n),
        .i_vsync       (vid.i_vsync),
        .i_de          (vid.i_de),
        .o_x           (x_s1),
        .o_y           (y_s1),
        .o_frame_start (fs_s1)
    );

    always_comb begin
        cb        = vid.i_ycbcr[15:8];
        cr        = vid.i_ycbcr[7:0];
        skin_s1_d = vid.i_de
                    && (cb >= CB_MIN) && (cb <= CB_MAX)
                    && (cr >= CR_MIN) && (cr <= CR_MAX);
        rgb_s1_d  = vid.i_rgb;
        hs_s1_d   = vid.i_hsync;
        vs_s1_d   = vid.i_vsync;
        de_s1_d   = vid.i_de;
        mode_s1_d = vid.i_mode;
    end

    always_comb begin
        acc_d   = acc_q;
        box_d   = box_q;
        valid_d = valid_q;
        // A skin pixel landing on the frame-start cycle is dropped on purpose.
        if (fs_s1) begin
            box_d   = acc_q;
            valid_d = (acc_q.cnt >= MIN_PIX);
            acc_d   = bbox_init();
        end else if (skin_s1_q) begin
            if (x_s1 < acc_q.x_min) acc_d.x_min = x_s1;
            if (x_s1 > acc_q.x_max) acc_d.x_max = x_s1;
            if (y_s1 < acc_q.y_min) acc_d.y_min = y_s1;
            if (y_s1 > acc_q.y_max) acc_d.y_max = y_s1;
            if (!(&acc_q.cnt)) acc_d.cnt = acc_q.cnt + CNT_ONE;
        end
    end

    always_comb begin
        on_x   = (x_s1 == box_q.x_min) || (x_s1 == box_q.x_max);
        on_y   = (y_s1 == box_q.y_min) || (y_s1 == box_q.y_max);
        in_x   = (x_s1 >= box_q.x_min) && (x_s1 <= box_q.x_max);
        in_y   = (y_s1 >= box_q.y_min) && (y_s1 <= box_q.y_max);
        border = (on_x && in_y) || (on_y && in_x);
        rgb_d  = rgb_s1_q;
        if (!de_s1_q) begin
            rgb_d = '0;
        end else if (mode_s1_q) begin
            rgb_d = skin_s1_q ? MASK_ON : MASK_OFF;
        end else if (valid_q && border) begin
            rgb_d = BOX_COLOR;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1_q  <= '0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            de_s1_q   <= 1'b0;
            mode_s1_q <= 1'b0;
            skin_s1_q <= 1'b0;
            acc_q     <= bbox_init();
            box_q     <= '0;
            valid_q   <= 1'b0;
            rgb_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            mask_q    <= 1'b0;
        end else begin
            rgb_s1_q  <= rgb_s1_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            de_s1_q   <= de_s1_d;
            mode_s1_q <= mode_s1_d;
            skin_s1_q <= skin_s1_d;
            acc_q     <= acc_d;
            box_q     <= box_d;
            valid_q   <= valid_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_s1_q;
            vs_q      <= vs_s1_q;
            de_q      <= de_s1_q;
            mask_q    <= skin_s1_q;
        end
    end

    assign vid.o_rgb   = rgb_q;
    assign vid.o_hsync = hs_q;
    assign vid.o_vsync = vs_q;
    assign vid.o_de    = de_q;
    assign vid.o_mask  = mask_q;

    assign o_box_valid = valid_q;
    assign o_x_min     = box_q.x_min;
    assign o_x_max     = box_q.x_max;
    assign o_y_min     = box_q.y_min;
    assign o_y_max     = box_q.y_max;
    assign o_pix_cnt   = box_q.cnt;

endmodule

// File: tb/tb_skin_bbox_detect.sv
// Directed bench for skin_bbox_detect: two instances (MIN_PIX 1 and 4)
// fed the same stream, 8x4 frames, hand-computed expectations.
module tb_skin_bbox_detect;

    localparam logic [23:0] SKIN = {8'd80, 8'd100, 8'd150};
    localparam logic [23:0] NOSK = {8'd80, 8'd50, 8'd50};

    logic pixelclk;
    logic reset_n;

    skin_bbox_detect_if vif1 ();
    skin_bbox_detect_if vif4 ();

    logic        valid1, valid4;
    logic [11:0] xmin1, xmax1, ymin1, ymax1;
    logic [11:0] xmin4, xmax4, ymin4, ymax4;
    logic [21:0] cnt1, cnt4;

    skin_bbox_detect #(.MIN_PIX(22'd1)) dut1 (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .vid         (vif1.slave),
        .o_box_valid (valid1),
        .o_x_min     (xmin1),
        .o_x_max     (xmax1),
        .o_y_min     (ymin1),
        .o_y_max     (ymax1),
        .o_pix_cnt   (cnt1)
    );

    skin_bbox_detect #(.MIN_PIX(22'd4)) dut4 (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .vid         (vif4.slave),
        .o_box_valid (valid4),
        .o_x_min     (xmin4),
        .o_x_max     (xmax4),
        .o_y_min     (ymin4),
        .o_y_max     (ymax4),
        .o_pix_cnt   (cnt4)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    int          n_cmp;
    int          n_bad;
    int          prev_tag;
    logic        mode;
    logic [23:0] cap_rgb [32];
    logic        cap_mask [32];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [23:0] ycc, input logic [23:0] rgb,
                         input logic hs, input logic vs, input logic de);
        vif1.i_ycbcr = ycc; vif4.i_ycbcr = ycc;
        vif1.i_rgb   = rgb; vif4.i_rgb   = rgb;
        vif1.i_hsync = hs;  vif4.i_hsync = hs;
        vif1.i_vsync = vs;  vif4.i_vsync = vs;
        vif1.i_de    = de;  vif4.i_de    = de;
        vif1.i_mode  = mode; vif4.i_mode = mode;
    endtask

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    // After one edge the outputs belong to the previously driven cycle.
    task automatic cyc(input logic [23:0] ycc, input logic [23:0] rgb,
                       input logic hs, input logic vs, input logic de,
                       input int tag);
        drive(ycc, rgb, hs, vs, de);
        tick();
        if (prev_tag >= 0) begin
            cap_rgb[prev_tag]  = vif1.o_rgb;
            cap_mask[prev_tag] = vif1.o_mask;
        end
        prev_tag = tag;
    endtask

    task automatic vs_edge(input logic skin_on_edge);
        cyc(skin_on_edge ? SKIN : NOSK, 24'h0, 1'b0, 1'b1, skin_on_edge, -1);
        cyc(NOSK, 24'h0, 1'b0, 1'b1, 1'b0, -1);
        cyc(NOSK, 24'h0, 1'b0, 1'b0, 1'b0, -1);
        cyc(NOSK, 24'h0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic send_frame(input logic [31:0] map, input logic [23:0] rgb);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                cyc(map[y*8+x] ? SKIN : NOSK, rgb, 1'b0, 1'b0, 1'b1, y*8+x);
            end
            for (int b = 0; b < 3; b++) begin
                cyc(NOSK, 24'h0, b == 0, 1'b0, 1'b0, -1);
            end
        end
    endtask

    logic [2:0]  lat_prv;
    logic [2:0]  lat_cur;
    logic [23:0] thr [6];
    logic        thr_exp [6];

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        prev_tag = -1;
        mode     = 1'b0;
        reset_n  = 1'b0;
        drive(NOSK, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        chk("rst_valid", {31'd0, valid1}, 32'd0);
        chk("rst_xmin", {20'd0, xmin1}, 32'd0);
        chk("rst_cnt", {10'd0, cnt1}, 32'd0);
        chk("rst_rgb", {8'd0, vif1.o_rgb}, 32'd0);
        chk("rst_de", {31'd0, vif1.o_de}, 32'd0);

        reset_n = 1'b1;
        repeat (2) tick();

        vs_edge(1'b0);
        chk("empty_xmin", {20'd0, xmin1}, 32'hFFF);
        chk("empty_xmax", {20'd0, xmax1}, 32'd0);
        chk("empty_ymin", {20'd0, ymin1}, 32'hFFF);
        chk("empty_cnt", {10'd0, cnt1}, 32'd0);
        chk("empty_valid", {31'd0, valid1}, 32'd0);

        lat_prv = 3'b000;
        for (int i = 0; i < 24; i++) begin
            lat_cur = 3'($urandom_range(0, 7));
            drive(NOSK, 24'h123456, lat_cur[2], lat_cur[1], lat_cur[0]);
            tick();
            if (i > 0) begin
                chk("latency_sync",
                    {29'd0, vif1.o_hsync, vif1.o_vsync, vif1.o_de},
                    {29'd0, lat_prv});
                if (!lat_prv[0]) begin
                    chk("blank_rgb", {8'd0, vif1.o_rgb}, 32'd0);
                end
            end
            lat_prv = lat_cur;
        end

        thr[0] = {8'd80, 8'd77, 8'd133};  thr_exp[0] = 1'b1;
        thr[1] = {8'd80, 8'd76, 8'd150};  thr_exp[1] = 1'b0;
        thr[2] = {8'd80, 8'd100, 8'd173}; thr_exp[2] = 1'b1;
        thr[3] = {8'd80, 8'd100, 8'd174}; thr_exp[3] = 1'b0;
        thr[4] = {8'd80, 8'd127, 8'd150}; thr_exp[4] = 1'b1;
        thr[5] = {8'd80, 8'd128, 8'd150}; thr_exp[5] = 1'b0;
        mode = 1'b1;
        vs_edge(1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(thr[i], 24'h0, 1'b0, 1'b0, 1'b1, i);
        end
        for (int b = 0; b < 3; b++) begin
            cyc(NOSK, 24'h0, 1'b0, 1'b0, 1'b0, -1);
        end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("thr_mask%0d", i), {31'd0, cap_mask[i]},
                {31'd0, thr_exp[i]});
        end
        chk("mask_rgb_on", {8'd0, cap_rgb[0]}, 32'hFFFFFF);
        chk("mask_rgb_off", {8'd0, cap_rgb[1]}, 32'h000000);
        mode = 1'b0;

        vs_edge(1'b0);
        send_frame(32'h1 << 19, 24'h0);
        vs_edge(1'b0);
        chk("one_xmin", {20'd0, xmin1}, 32'd3);
        chk("one_xmax", {20'd0, xmax1}, 32'd3);
        chk("one_ymin", {20'd0, ymin1}, 32'd2);
        chk("one_ymax", {20'd0, ymax1}, 32'd2);
        chk("one_cnt", {10'd0, cnt1}, 32'd1);
        chk("one_valid", {31'd0, valid1}, 32'd1);
        chk("one_valid_mp4", {31'd0, valid4}, 32'd0);

        send_frame((32'h1 << 10) | (32'h1 << 29), 24'h0);
        vs_edge(1'b0);
        chk("box_xmin", {20'd0, xmin1}, 32'd2);
        chk("box_xmax", {20'd0, xmax1}, 32'd5);
        chk("box_ymin", {20'd0, ymin1}, 32'd1);
        chk("box_ymax", {20'd0, ymax1}, 32'd3);
        send_frame(32'h0, 24'h123456);
        chk("ovl_2_2", {8'd0, cap_rgb[18]}, 32'hFF0000);
        chk("ovl_3_2", {8'd0, cap_rgb[19]}, 32'h123456);
        chk("ovl_4_1", {8'd0, cap_rgb[12]}, 32'hFF0000);
        chk("ovl_6_2", {8'd0, cap_rgb[22]}, 32'h123456);
        chk("ovl_0_0", {8'd0, cap_rgb[0]}, 32'h123456);

        for (int i = 0; i < 3; i++) begin
            cyc(NOSK, 24'h123456, 1'b0, 1'b0, 1'b1, -1);
        end
        chk("pre_rst_valid", {31'd0, valid1}, 32'd1);
        @(posedge pixelclk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("amid_valid", {31'd0, valid1}, 32'd0);
        chk("amid_xmax", {20'd0, xmax1}, 32'd0);
        chk("amid_de", {31'd0, vif1.o_de}, 32'd0);
        chk("amid_rgb", {8'd0, vif1.o_rgb}, 32'd0);
        @(posedge pixelclk);
        #2;
        reset_n  = 1'b1;
        prev_tag = -1;
        drive(NOSK, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("post_rst_valid", {31'd0, valid1}, 32'd0);
        chk("post_rst_xmin", {20'd0, xmin1}, 32'd0);

        vs_edge(1'b0);
        send_frame((32'h1 << 1) | (32'h1 << 14) | (32'h1 << 28), 24'h0);
        vs_edge(1'b1);
        chk("mp4_valid", {31'd0, valid4}, 32'd0);
        chk("mp4_cnt", {10'd0, cnt4}, 32'd3);
        chk("mp4_xmin", {20'd0, xmin4}, 32'd1);
        chk("mp4_xmax", {20'd0, xmax4}, 32'd6);
        chk("mp4_ymin", {20'd0, ymin4}, 32'd0);
        chk("mp4_ymax", {20'd0, ymax4}, 32'd3);
        chk("mp1_valid", {31'd0, valid1}, 32'd1);
        chk("mp1_cnt", {10'd0, cnt1}, 32'd3);

        send_frame(32'h0, 24'h0);
        vs_edge(1'b0);
        chk("edge_px_dropped4", {10'd0, cnt4}, 32'd0);
        chk("edge_px_dropped1", {10'd0, cnt1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
